hazard_control: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RV32I core; sits in decode/execute, alongside and upstream of the EX-stage operand forwarding logic.
- Resolves hazards that forwarding cannot cover: load-use and CSR-use dependencies, taken-branch/trap redirects, instruction-fetch waits and multi-cycle data-memory waits.
- Drives stall/flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers, and keeps stall/flush performance counters.

---
 rtl/hazard_control.sv | 147 ++++++++++++++
 tb/tb_hazard_control.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard/stall controller: load-use and CSR-use interlocks, redirect
// flushes, fetch and data-memory waits, plus stall/flush performance counters.
module hazard_control #(
    parameter int unsigned DMEM_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1addr_d,
    input  logic [4:0]       rs2addr_d,
    input  logic             rs1used_d,
    input  logic             rs2used_d,
    input  logic [4:0]       rd_e,
    input  logic             memre_e,
    input  logic             csrwe_e,
    input  logic             redirect_e,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             redirect_ok,
    output logic             dmem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(DMEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              hazard_lu;
    logic              pipe_eval;

    assign hazard_lu = (memre_e | csrwe_e) && (rd_e != 5'd0) &&
                       ((rs1used_d && (rs1addr_d == rd_e)) ||
                        (rs2used_d && (rs2addr_d == rd_e)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (stall_f)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect_ok && redirect_e)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;
        redirect_ok  = 1'b0;
        dmem_timeout = 1'b0;
        state_nxt    = state;
        wcnt_nxt     = wcnt;
        pipe_eval    = 1'b0;

        if (rst) begin
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            flush_w   = 1'b1;
            state_nxt = RUN;
            wcnt_nxt  = '0;
        end else begin
            case (state)
                RUN: begin
                    if (dmem_req_m && !dmem_ready) begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                        flush_w   = 1'b1;
                        state_nxt = MEM_WAIT;
                        wcnt_nxt  = WCNT_W'(1);
                    end else begin
                        pipe_eval = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        pipe_eval = 1'b1;
                        state_nxt = RUN;
                        wcnt_nxt  = '0;
                    end else begin
                        {stall_f, stall_d, stall_e, stall_m} = '1;
                        flush_w = 1'b1;
                        if (wcnt >= WCNT_MAX) begin
                            state_nxt = ERR;
                            wcnt_nxt  = '0;
                        end else begin
                            wcnt_nxt = wcnt + WCNT_W'(1);
                        end
                    end
                end
                ERR: begin
                    dmem_timeout = 1'b1;
                    flush_d      = 1'b1;
                    flush_e      = 1'b1;
                    flush_w      = 1'b1;
                    state_nxt    = RUN;
                    wcnt_nxt     = '0;
                end
                default: begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end
            endcase

            // A load-use stall also covers a missing fetch: holding IF/ID beats bubbling it.
            if (pipe_eval) begin
                if (redirect_e) begin
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    redirect_ok = 1'b1;
                end else if (hazard_lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (!imem_ready) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// Directed-vector bench for hazard_control; output bits packed as
// {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,redirect_ok,dmem_timeout}.
module tb_hazard_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1addr_d, rs2addr_d, rd_e;
    logic        rs1used_d, rs2used_d, memre_e, csrwe_e, redirect_e;
    logic        imem_ready, dmem_req_m, dmem_ready;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w, redirect_ok, dmem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] P_IDLE  = 9'b0000_000_0_0;
    localparam logic [8:0] P_RST   = 9'b0000_111_0_0;
    localparam logic [8:0] P_LU    = 9'b1100_010_0_0;
    localparam logic [8:0] P_FETCH = 9'b1000_100_0_0;
    localparam logic [8:0] P_REDIR = 9'b0000_110_1_0;
    localparam logic [8:0] P_MEMW  = 9'b1111_001_0_0;
    localparam logic [8:0] P_ERR   = 9'b0000_111_0_1;

    always #5 clk = ~clk;

    hazard_control #(.DMEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .rs1addr_d(rs1addr_d), .rs2addr_d(rs2addr_d),
        .rs1used_d(rs1used_d), .rs2used_d(rs2used_d),
        .rd_e(rd_e), .memre_e(memre_e), .csrwe_e(csrwe_e),
        .redirect_e(redirect_e), .imem_ready(imem_ready),
        .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .redirect_ok(redirect_ok), .dmem_timeout(dmem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [8:0] outs();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                redirect_ok, dmem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1addr_d = 5'd0; rs2addr_d = 5'd0; rs1used_d = 1'b0; rs2used_d = 1'b0;
        rd_e = 5'd0; memre_e = 1'b0; csrwe_e = 1'b0; redirect_e = 1'b0;
        imem_ready = 1'b1; dmem_req_m = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'(P_RST));
        next_cycle();
        next_cycle();
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b0;

        @(negedge clk);
        check("idle", 32'(outs()), 32'(P_IDLE));

        // load to x5, decode reads x5 through rs2
        next_cycle();
        memre_e = 1'b1; rd_e = 5'd5; rs2addr_d = 5'd5; rs2used_d = 1'b1;
        @(negedge clk);
        check("load_use_rs2", 32'(outs()), 32'(P_LU));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("load_use_release", 32'(outs()), 32'(P_IDLE));
        check("stall_cnt_1", stall_cnt, 32'd1);

        // load to x0 never interlocks
        next_cycle();
        memre_e = 1'b1; rd_e = 5'd0; rs1addr_d = 5'd0; rs1used_d = 1'b1;
        @(negedge clk);
        check("load_x0", 32'(outs()), 32'(P_IDLE));

        // rs2 match but rs2 unused
        next_cycle();
        idle_inputs();
        memre_e = 1'b1; rd_e = 5'd9; rs2addr_d = 5'd9; rs2used_d = 1'b0;
        @(negedge clk);
        check("load_rs2_unused", 32'(outs()), 32'(P_IDLE));

        // CSR-use on x7 via rs1
        next_cycle();
        idle_inputs();
        csrwe_e = 1'b1; rd_e = 5'd7; rs1addr_d = 5'd7; rs1used_d = 1'b1;
        @(negedge clk);
        check("csr_use", 32'(outs()), 32'(P_LU));

        // same hazard with fetch stalled: IF/ID held, not bubbled
        next_cycle();
        imem_ready = 1'b0;
        @(negedge clk);
        check("lu_and_fetch", 32'(outs()), 32'(P_LU));
        check("stall_cnt_2", stall_cnt, 32'd2);

        next_cycle();
        idle_inputs();
        imem_ready = 1'b0;
        @(negedge clk);
        check("fetch_wait", 32'(outs()), 32'(P_FETCH));
        check("stall_cnt_3", stall_cnt, 32'd3);

        // redirect beats load-use and fetch wait
        next_cycle();
        memre_e = 1'b1; rd_e = 5'd5; rs1addr_d = 5'd5; rs1used_d = 1'b1;
        redirect_e = 1'b1; imem_ready = 1'b0;
        @(negedge clk);
        check("redirect_over_lu", 32'(outs()), 32'(P_REDIR));
        check("stall_cnt_4", stall_cnt, 32'd4);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("flush_cnt_1", flush_cnt, 32'd1);
        check("stall_cnt_4b", stall_cnt, 32'd4);

        // 3 cycles of dmem wait with a redirect held throughout
        next_cycle();
        dmem_req_m = 1'b1; dmem_ready = 1'b0; redirect_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("memwait_%0d", i), 32'(outs()), 32'(P_MEMW));
            next_cycle();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("memwait_release", 32'(outs()), 32'(P_REDIR));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("after_release", 32'(outs()), 32'(P_IDLE));
        check("flush_cnt_2", flush_cnt, 32'd2);
        check("stall_cnt_7", stall_cnt, 32'd7);

        // dmem never ready: 1 RUN stall cycle + 16 MEM_WAIT cycles, then ERR
        next_cycle();
        dmem_req_m = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check($sformatf("timeout_wait_%0d", i), 32'(outs()), 32'(P_MEMW));
            next_cycle();
        end
        @(negedge clk);
        check("timeout_err", 32'(outs()), 32'(P_ERR));
        next_cycle();
        dmem_req_m = 1'b0;
        @(negedge clk);
        check("after_err_run", 32'(outs()), 32'(P_IDLE));
        check("stall_cnt_24", stall_cnt, 32'd24);

        // reset in the middle of MEM_WAIT
        next_cycle();
        dmem_req_m = 1'b1; dmem_ready = 1'b0;
        next_cycle();
        @(negedge clk);
        check("pre_rst_memwait", 32'(outs()), 32'(P_MEMW));
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_memwait", 32'(outs()), 32'(P_RST));
        next_cycle();
        rst = 1'b0;
        dmem_req_m = 1'b0;
        @(negedge clk);
        check("rst_back_to_run", 32'(outs()), 32'(P_IDLE));
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
